// File: rtl/nco_sweep_ctrl.sv
// NCO frequency-acquisition sweep: steps bins, dwells, tracks best bin, parks on it.
// Latency: start -> LOAD after one edge; per bin 1 + SETTLE_CYC + dwell + 1 cycles; all outputs registered.
// Backpressure: none; dwell stalls while corr_valid is low. Optional early lock via NCO_SWEEP_EARLY_LOCK_EN.
module nco_sweep_ctrl #(
  parameter int WORD_W     = 13,
  parameter int BIN_W      = 6,
  parameter int DWELL_W    = 16,
  parameter int EN_W       = 16,
  parameter int ACC_W      = 24,
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WORD_W-1:0]  f_start,
  input  logic [WORD_W-1:0]  f_step,
  input  logic [BIN_W-1:0]   n_bins,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [ACC_W-1:0]   threshold,
  input  logic               corr_valid,
  input  logic [EN_W-1:0]    corr_energy,
  output logic [WORD_W-1:0]  nco_word,
  output logic               nco_rst,
  output logic               busy,
  output logic               locked,
  output logic               done,
  output logic [WORD_W-1:0]  best_word,
  output logic [ACC_W-1:0]   best_energy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_DWELL, S_EVAL, S_PARK, S_LOCKED
  } state_t;

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  bin_word_q, bin_word_d;
  logic [WORD_W-1:0]  step_q, step_d;
  logic [BIN_W-1:0]   nbins_q, nbins_d;
  logic [BIN_W-1:0]   bin_idx_q, bin_idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WORD_W-1:0]  best_word_q, best_word_d;
  logic [ACC_W-1:0]   best_energy_q, best_energy_d;
  logic [WORD_W-1:0]  nco_word_q, nco_word_d;
  logic               nco_rst_q, nco_rst_d;
  logic               busy_q, busy_d;
  logic               locked_q, locked_d;
  logic               done_q, done_d;
  logic [ACC_W:0]     acc_sum;
  logic [ACC_W-1:0]   acc_sat;
  logic               take_best;
  logic               sweep_end;

`ifdef NCO_SWEEP_EARLY_LOCK_EN
  logic [ACC_W-1:0]   thr_q, thr_d;
`else
  logic               unused_threshold;
  assign unused_threshold = ^threshold;
`endif

  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(corr_energy);
  assign acc_sat = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];

  always_comb begin
    state_d       = state_q;
    bin_word_d    = bin_word_q;
    step_d        = step_q;
    nbins_d       = nbins_q;
    bin_idx_d     = bin_idx_q;
    dwell_d       = dwell_q;
    sample_cnt_d  = sample_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    acc_d         = acc_q;
    best_word_d   = best_word_q;
    best_energy_d = best_energy_q;
    take_best     = 1'b0;
    sweep_end     = 1'b0;
`ifdef NCO_SWEEP_EARLY_LOCK_EN
    thr_d         = thr_q;
`endif

    // abort wins over everything, including a simultaneous start, and keeps best_*
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_LOCKED: begin
          if (start) begin
            state_d       = S_LOAD;
            bin_word_d    = f_start;
            step_d        = f_step;
            nbins_d       = (n_bins == '0) ? BIN_W'(1) : n_bins;
            dwell_d       = (dwell == '0) ? DWELL_W'(1) : dwell;
            bin_idx_d     = '0;
            best_word_d   = '0;
            best_energy_d = '0;
`ifdef NCO_SWEEP_EARLY_LOCK_EN
            thr_d         = threshold;
`endif
          end
        end
        S_LOAD: begin
          acc_d        = '0;
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
            sample_cnt_d = '0;
            state_d      = S_DWELL;
          end else begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
          end
        end
        S_DWELL: begin
          if (corr_valid) begin
            acc_d = acc_sat;
            if (sample_cnt_q == dwell_q - DWELL_W'(1)) begin
              state_d = S_EVAL;
            end else begin
              sample_cnt_d = sample_cnt_q + DWELL_W'(1);
            end
          end
        end
        S_EVAL: begin
          take_best = (acc_q > best_energy_q);
          sweep_end = (bin_idx_q == nbins_q - BIN_W'(1));
`ifdef NCO_SWEEP_EARLY_LOCK_EN
          if (acc_q >= thr_q) begin
            take_best = 1'b1;
            sweep_end = 1'b1;
          end
`endif
          if (take_best) begin
            best_word_d   = bin_word_q;
            best_energy_d = acc_q;
          end
          if (sweep_end) begin
            state_d = S_PARK;
          end else begin
            bin_word_d = bin_word_q + step_q;
            bin_idx_d  = bin_idx_q + BIN_W'(1);
            state_d    = S_LOAD;
          end
        end
        S_PARK:  state_d = S_LOCKED;
        default: state_d = S_IDLE;
      endcase
    end

    // outputs are decoded from the next state so they line up with it after the edge
    nco_word_d = '0;
    nco_rst_d  = 1'b0;
    busy_d     = 1'b0;
    locked_d   = 1'b0;
    done_d     = 1'b0;
    unique case (state_d)
      S_IDLE: nco_rst_d = 1'b1;
      S_LOAD: begin
        nco_word_d = bin_word_d;
        nco_rst_d  = 1'b1;
        busy_d     = 1'b1;
      end
      S_SETTLE, S_DWELL, S_EVAL: begin
        nco_word_d = bin_word_d;
        busy_d     = 1'b1;
      end
      S_PARK: begin
        nco_word_d = best_word_d;
        nco_rst_d  = 1'b1;
        busy_d     = 1'b1;
        done_d     = 1'b1;
      end
      S_LOCKED: begin
        nco_word_d = best_word_d;
        locked_d   = 1'b1;
      end
      default: nco_rst_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      bin_word_q    <= '0;
      step_q        <= '0;
      nbins_q       <= '0;
      bin_idx_q     <= '0;
      dwell_q       <= '0;
      sample_cnt_q  <= '0;
      settle_cnt_q  <= '0;
      acc_q         <= '0;
      best_word_q   <= '0;
      best_energy_q <= '0;
      nco_word_q    <= '0;
      nco_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      locked_q      <= 1'b0;
      done_q        <= 1'b0;
`ifdef NCO_SWEEP_EARLY_LOCK_EN
      thr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bin_word_q    <= bin_word_d;
      step_q        <= step_d;
      nbins_q       <= nbins_d;
      bin_idx_q     <= bin_idx_d;
      dwell_q       <= dwell_d;
      sample_cnt_q  <= sample_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      acc_q         <= acc_d;
      best_word_q   <= best_word_d;
      best_energy_q <= best_energy_d;
      nco_word_q    <= nco_word_d;
      nco_rst_q     <= nco_rst_d;
      busy_q        <= busy_d;
      locked_q      <= locked_d;
      done_q        <= done_d;
`ifdef NCO_SWEEP_EARLY_LOCK_EN
      thr_q         <= thr_d;
`endif
    end
  end

  assign nco_word    = nco_word_q;
  assign nco_rst     = nco_rst_q;
  assign busy        = busy_q;
  assign locked      = locked_q;
  assign done        = done_q;
  assign best_word   = best_word_q;
  assign best_energy = best_energy_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: a per-cycle timeline model built from the sweep rules,
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_nco_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam longint ACC_MAX = 64'hFF_FFFF;
`ifdef NCO_SWEEP_EARLY_LOCK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [12:0] f_start = '0, f_step = '0;
  logic [5:0]  n_bins = '0;
  logic [15:0] dwell = '0;
  logic [23:0] threshold = '0;
  logic        corr_valid = 1'b0;
  logic [15:0] corr_energy = '0;
  logic [12:0] nco_word, best_word;
  logic        nco_rst, busy, locked, done;
  logic [23:0] best_energy;

  nco_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_bins(n_bins), .dwell(dwell),
    .threshold(threshold), .corr_valid(corr_valid), .corr_energy(corr_energy),
    .nco_word(nco_word), .nco_rst(nco_rst), .busy(busy), .locked(locked),
    .done(done), .best_word(best_word), .best_energy(best_energy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] word;
    logic        rst, bsy, lck, dn;
    logic [12:0] bword;
    logic [23:0] benergy;
    logic        vld;
    logic [15:0] en;
    logic        ab;
  } cyc_t;

  cyc_t tl[$];
  int   bin_en[64];
  int   errors = 0;
  int   checks = 0;
  int   done_seen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic cyc_t mk(input int w, input bit r, input bit b, input bit l, input bit d,
                              input int bw, input longint be, input int en);
    cyc_t c;
    c.word = 13'(w); c.rst = r; c.bsy = b; c.lck = l; c.dn = d;
    c.bword = 13'(bw); c.benergy = 24'(be);
    c.vld = 1'b1; c.en = 16'(en); c.ab = 1'b0;
    return c;
  endfunction

  // Expected per-cycle trace, cycle 0 being the first cycle after the start edge.
  // Junk energy is offered outside DWELL; it must never reach the accumulator.
  task automatic build(input int fs, input int st, input int nb_raw, input int d_raw,
                       input longint thr, input int abort_k);
    int nb, d, w, bw, hold_bw;
    longint be, acc, hold_be;
    nb = (nb_raw == 0) ? 1 : nb_raw;
    d  = (d_raw == 0) ? 1 : d_raw;
    bw = 0; be = 0;
    tl.delete();
    for (int b = 0; b < nb; b++) begin
      w = (fs + b * st) % 8192;
      tl.push_back(mk(w, 1, 1, 0, 0, bw, be, 16'hFFFF));
      for (int s = 0; s < SETTLE; s++) tl.push_back(mk(w, 0, 1, 0, 0, bw, be, 16'hFFFF));
      for (int i = 0; i < d; i++) tl.push_back(mk(w, 0, 1, 0, 0, bw, be, bin_en[b]));
      tl.push_back(mk(w, 0, 1, 0, 0, bw, be, 16'hFFFF));
      acc = longint'(d) * bin_en[b];
      if (acc > ACC_MAX) acc = ACC_MAX;
      if (acc > be || (EARLY && acc >= thr)) begin
        bw = w; be = acc;
      end
      if (EARLY && acc >= thr) break;
    end
    tl.push_back(mk(bw, 1, 1, 0, 1, bw, be, 16'hFFFF));
    for (int i = 0; i < 3; i++) tl.push_back(mk(bw, 0, 0, 1, 0, bw, be, 16'hFFFF));
    if (abort_k >= 0) begin
      hold_bw = tl[abort_k].bword;
      hold_be = tl[abort_k].benergy;
      tl[abort_k].ab = 1'b1;
      while (tl.size() > abort_k + 1) void'(tl.pop_back());
      for (int i = 0; i < 3; i++) tl.push_back(mk(0, 1, 0, 0, 0, hold_bw, hold_be, 16'hFFFF));
    end
  endtask

  task automatic run(input string tag, input int fs, input int st, input int nb, input int d,
                     input longint thr, input int abort_k);
    build(fs, st, nb, d, thr, abort_k);
    done_seen = 0;
    @(negedge clk);
    f_start = 13'(fs); f_step = 13'(st); n_bins = 6'(nb); dwell = 16'(d);
    threshold = 24'(thr); start = 1'b1; abort = 1'b0; corr_valid = 1'b0;
    for (int k = 0; k < tl.size(); k++) begin
      @(negedge clk);
      check($sformatf("%s k=%0d nco_word", tag, k), 32'(nco_word), 32'(tl[k].word));
      check($sformatf("%s k=%0d nco_rst", tag, k), 32'(nco_rst), 32'(tl[k].rst));
      check($sformatf("%s k=%0d busy", tag, k), 32'(busy), 32'(tl[k].bsy));
      check($sformatf("%s k=%0d locked", tag, k), 32'(locked), 32'(tl[k].lck));
      check($sformatf("%s k=%0d done", tag, k), 32'(done), 32'(tl[k].dn));
      check($sformatf("%s k=%0d best_word", tag, k), 32'(best_word), 32'(tl[k].bword));
      check($sformatf("%s k=%0d best_energy", tag, k), 32'(best_energy), 32'(tl[k].benergy));
      if (done === 1'b1) done_seen++;
      start = tl[k].ab; abort = tl[k].ab;
      corr_valid = tl[k].vld; corr_energy = tl[k].en;
      // mid-sweep config changes must be ignored
      f_start = 13'($urandom); f_step = 13'($urandom); n_bins = 6'($urandom);
      dwell = 16'($urandom_range(1, 40)); threshold = 24'($urandom_range(0, 5));
    end
    start = 1'b0; abort = 1'b0; corr_valid = 1'b0;
  endtask

  initial begin
    // reset and idle
    #12;
    check("in_reset nco_rst", 32'(nco_rst), 32'd1);
    check("in_reset busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle nco_word", 32'(nco_word), 32'd0);
    check("idle nco_rst", 32'(nco_rst), 32'd1);
    check("idle busy", 32'(busy), 32'd0);
    check("idle locked", 32'(locked), 32'd0);
    check("idle done", 32'(done), 32'd0);
    check("idle best_word", 32'(best_word), 32'd0);
    check("idle best_energy", 32'(best_energy), 32'd0);

    // basic sweep: bin 1 wins the tie with bin 3
    bin_en[0] = 10; bin_en[1] = 50; bin_en[2] = 20; bin_en[3] = 50;
    run("basic", 'h100, 'h040, 4, 3, ACC_MAX, -1);
    check("basic lit best_word", 32'(best_word), 32'h140);
    check("basic lit best_energy", 32'(best_energy), 32'd150);
    check("basic lit done_pulses", 32'(done_seen), 32'd1);
    check("basic lit locked", 32'(locked), 32'd1);
    check("basic lit nco_word", 32'(nco_word), 32'h140);

    // word wrap, started from LOCKED
    bin_en[0] = 3; bin_en[1] = 4;
    run("wrap", 'h1FC0, 'h0080, 2, 2, ACC_MAX, -1);
    check("wrap lit best_word", 32'(best_word), 32'h0040);
    check("wrap lit best_energy", 32'(best_energy), 32'd8);

    // accumulator saturation
    bin_en[0] = 'hFFFF;
    run("sat", 'h0AA, 'h001, 1, 512, ACC_MAX, -1);
    check("sat lit best_energy", 32'(best_energy), 32'hFF_FFFF);

    // abort mid-DWELL of bin 2 with start in the same cycle
    bin_en[0] = 5; bin_en[1] = 7; bin_en[2] = 9; bin_en[3] = 1;
    run("abort", 'h200, 'h010, 4, 3, ACC_MAX, 18);
    check("abort lit best_word", 32'(best_word), 32'h210);
    check("abort lit best_energy", 32'(best_energy), 32'd21);
    check("abort lit done_pulses", 32'(done_seen), 32'd0);
    check("abort lit busy", 32'(busy), 32'd0);

    // zero config: one bin, one sample
    bin_en[0] = 9;
    run("zero", 'h055, 'h111, 0, 0, ACC_MAX, -1);
    check("zero lit best_word", 32'(best_word), 32'h055);
    check("zero lit best_energy", 32'(best_energy), 32'd9);
    check("zero lit done_pulses", 32'(done_seen), 32'd1);

`ifdef NCO_SWEEP_EARLY_LOCK_EN
    bin_en[0] = 10; bin_en[1] = 40; bin_en[2] = 60; bin_en[3] = 70;
    run("early", 'h300, 'h020, 4, 3, 100, -1);
    check("early lit best_word", 32'(best_word), 32'h320);
    check("early lit best_energy", 32'(best_energy), 32'd120);
    check("early lit done_pulses", 32'(done_seen), 32'd1);
`endif

    // asynchronous reset in the middle of a sweep
    @(negedge clk);
    f_start = 13'h0123; f_step = 13'h0001; n_bins = 6'd3; dwell = 16'd2;
    threshold = 24'hFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; corr_valid = 1'b1; corr_energy = 16'd5;
    repeat (11) @(negedge clk);
    check("midrst pre busy", 32'(busy), 32'd1);
    check("midrst pre best_energy", 32'(best_energy), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst nco_rst", 32'(nco_rst), 32'd1);
    check("midrst nco_word", 32'(nco_word), 32'd0);
    check("midrst best_energy", 32'(best_energy), 32'd0);
    @(negedge clk); rst_n = 1'b1; corr_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
